// File: rtl/serial_add_sequencer.sv
// Bit-serial adder sequencer driving one shared external full-adder cell, LSB first.
// Optional ADDSUB_EN adds a `sub` input turning the operation into a - b.
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDSUB_EN
  input  logic             sub,
`endif
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] b_load_s;
  logic             carry_load_s;

  // Operand preparation at capture time: subtraction is a + ~b + 1.
  always_comb begin
    b_load_s     = b;
    carry_load_s = cin;
`ifdef ADDSUB_EN
    if (sub) begin
      b_load_s     = ~b;
      carry_load_s = 1'b1;
    end else begin
      b_load_s     = b;
      carry_load_s = cin;
    end
`endif
  end

  // Next-state and datapath; with ena low every register holds.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_sh_d  = a;
            b_sh_d  = b_load_s;
            carry_d = carry_load_s;
            cnt_d   = {CNT_W{1'b0}};
            sum_d   = {WIDTH{1'b0}};
            cout_d  = 1'b0;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
          carry_d = fa_cout;
          a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
          // Counter parks on the last index rather than wrapping.
          if (cnt_q == CNT_LAST) begin
            cout_d  = fa_cout;
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_d = S_RUN;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      a_sh_q  <= {WIDTH{1'b0}};
      b_sh_q  <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fa_a   = a_sh_q[0];
  assign fa_b   = b_sh_q[0];
  assign fa_cin = carry_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign sum    = sum_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed self-checking bench for serial_add_sequencer (WIDTH=8 cases plus a WIDTH=4 full sweep).
module tb_serial_add_sequencer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       fa_sum, fa_cout, fa_a, fa_b, fa_cin;
  logic       busy, done, cout;
  logic [7:0] sum;
`ifdef ADDSUB_EN
  logic       sub;
  logic       sub4;
`endif

  logic       ena4, start4, cin4;
  logic [3:0] a4, b4, sum4;
  logic       fa_sum4, fa_cout4, fa_a4, fa_b4, fa_cin4, busy4, done4, cout4;

  int checks;
  int errors;

  serial_add_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .a(a), .b(b), .cin(cin),
`ifdef ADDSUB_EN
    .sub(sub),
`endif
    .fa_sum(fa_sum), .fa_cout(fa_cout),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_sequencer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena4), .start(start4),
    .a(a4), .b(b4), .cin(cin4),
`ifdef ADDSUB_EN
    .sub(sub4),
`endif
    .fa_sum(fa_sum4), .fa_cout(fa_cout4),
    .fa_a(fa_a4), .fa_b(fa_b4), .fa_cin(fa_cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  // The shared full-adder cells the sequencers drive.
  assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout  = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
  assign fa_sum4  = fa_a4 ^ fa_b4 ^ fa_cin4;
  assign fa_cout4 = (fa_a4 & fa_b4) | (fa_a4 & fa_cin4) | (fa_b4 & fa_cin4);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One 8-bit operation; optional mid-run stall and an ignored second start.
  task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                     input logic tc, input logic tsub, input int stall_at,
                     input bit restart, input int exp_edges,
                     input logic [7:0] exp_sum, input logic exp_cout);
    int edges;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
`ifdef ADDSUB_EN
    sub = tsub;
`endif
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    while (!done && edges < 40) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      if (stall_at != 0 && edges == stall_at) ena = 1'b0;
      if (stall_at != 0 && edges == stall_at + 3) ena = 1'b1;
      if (restart && edges == 2) begin
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
      end
      if (restart && edges == 3) start = 1'b0;
      @(negedge clk);
      edges++;
    end
    check({tag, "_lat"}, edges, exp_edges);
    check({tag, "_sum"}, {24'd0, sum}, {24'd0, exp_sum});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
    check({tag, "_dbusy"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    check({tag, "_dpulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_hold"}, {24'd0, sum}, {24'd0, exp_sum});
  endtask

  // One 4-bit operation checked against a+b+cin.
  task automatic op4(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc);
    int edges;
    logic [4:0] exp;
    exp = {1'b0, ta} + {1'b0, tb_v} + {4'd0, tc};
    @(negedge clk);
    a4 = ta; b4 = tb_v; cin4 = tc; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    edges = 1;
    while (!done4 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check("w4_res", {26'd0, edges == 5, cout4, sum4}, {26'd0, 1'b1, exp});
    @(negedge clk);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0; cin = 1'b0;
    ena4 = 1'b1; start4 = 1'b0; a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;
`ifdef ADDSUB_EN
    sub = 1'b0; sub4 = 1'b0;
`endif
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    rst_n = 1'b1;

    op8("t1", 8'h5A, 8'h33, 1'b0, 1'b0, 0, 1'b0, 9, 8'h8D, 1'b0);
    op8("t2a", 8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0, 9, 8'h00, 1'b1);
    op8("t2b", 8'hFF, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 9, 8'hFF, 1'b1);
    op8("t3", 8'h5A, 8'h33, 1'b0, 1'b0, 0, 1'b1, 9, 8'h8D, 1'b0);
    op8("t4", 8'h5A, 8'h33, 1'b0, 1'b0, 4, 1'b0, 12, 8'h8D, 1'b0);
    op8("t7", 8'hC3, 8'h4E, 1'b1, 1'b0, 0, 1'b0, 9, 8'h12, 1'b1);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_partial", {24'd0, sum}, 32'h000000A0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_sum", {24'd0, sum}, 32'd0);
    check("t5_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op8("t5_fresh", 8'h5A, 8'h33, 1'b0, 1'b0, 0, 1'b0, 9, 8'h8D, 1'b0);

`ifdef ADDSUB_EN
    op8("t6a", 8'h10, 8'h01, 1'b0, 1'b1, 0, 1'b0, 9, 8'h0F, 1'b1);
    op8("t6b", 8'h01, 8'h02, 1'b0, 1'b1, 0, 1'b0, 9, 8'hFF, 1'b0);
    sub = 1'b0;
`endif

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        for (int k = 0; k < 2; k++) begin
          op4(4'(i), 4'(j), 1'(k));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
